data_memory_ctrl: RTL and testbench
===================================

// Module: data_memory_ctrl
// PURPOSE
//  Parametrised load/store data memory for the core's MEM stage. Adds to the basic
//  word memory:
//   - a valid/ready request/response handshake;
//   - configurable wait-state latency;
//   - byte/half/word accesses with sign or zero extension;
//   - misalignment and out-of-range error reporting;
//   - a sequential clear-on-reset init sweep.
//  One outstanding request at a time. Little-endian.
// PARAMETERS
//  DEPTH      64  number of 32-bit words (power of 2, >=2)
//  ADDR_W     32  byte-address width
//  LATENCY    1   wait cycles between accept and response (0..15)
//  INIT_CLEAR 1   1: zero every word after reset; 0: skip sweep, contents undefined
// PORTS
//  clk          in   1       clock, rising edge
//  rst          in   1       asynchronous, active-high reset
//  req_valid    in   1       request present
//  req_ready    out  1       block can accept a request
//  req_we       in   1       1 = store, 0 = load
//  req_size     in   2       00 byte, 01 half, 10 word, 11 illegal
//  req_unsigned in   1       load zero-extends when 1, sign-extends when 0
//  req_addr     in   ADDR_W  byte address
//  req_wdata    in   32      store data, right-aligned (byte in [7:0], half in [15:0])
//  rsp_valid    out  1       response present
//  rsp_ready    in   1       consumer takes the response
//  rsp_rdata    out  32      load result, extended; 0 for stores and errors
//  rsp_err      out  1       misaligned, illegal size or out of range
//  init_done    out  1       init sweep complete
// BEHAVIOUR
//  Reset (async): state=INIT, idx=0; req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0,
//   init_done=0. Mid-operation reset aborts the access; a pending store is discarded.
//  States: INIT -> IDLE -> WAIT -> RESP -> IDLE.
//  INIT: writes 0 to mem[idx], one word per cycle, for DEPTH cycles, then IDLE.
//   init_done is set on the same edge. With INIT_CLEAR=0, INIT lasts 1 cycle.
//  IDLE: req_ready=1; req_ready is low in every other state.
//   Accept on req_valid&&req_ready: latch all req_* fields; wait counter = LATENCY.
//  WAIT: counter decrements each cycle. The access edge is the edge where the counter is 0.
//   When LATENCY=0, the access edge is the edge after accept.
//   Net timing: accept at edge T -> rsp_valid rises at edge T+1+LATENCY.
//  Access edge: commit the store (if no error), register rsp_*, enter RESP.
//  RESP: rsp_valid=1. rsp_rdata and rsp_err are held stable until rsp_ready.
//   On rsp_valid&&rsp_ready: rsp_valid drops next edge, state -> IDLE.
//   No request is accepted in the same cycle as the response handshake.
//  Error (rsp_err=1), any of:
//   - size=11;
//   - half with addr[0]=1;
//   - word with addr[1:0]!=0;
//   - word index addr[ADDR_W-1:2] >= DEPTH.
//   On error: no memory change, rsp_rdata=0.
//  Load lanes: byte = word[8*addr[1:0]+:8]; half = word[16*addr[1]+:16].
//   Result is extended to 32 bits per req_unsigned.
//  Store lanes: only the addressed byte/half lanes change; the other lanes keep old data.
//  Memory is written only on the access edge or during INIT, never combinationally.
//  Read data is sampled from the word contents before that edge.
// STRUCTURE
//  Package data_mem_pkg holds:
//   - SZ_B=2'b00, SZ_H=2'b01, SZ_W=2'b10;
//   - state enum {INIT, IDLE, WAIT, RESP};
//   - the LATENCY counter width, $clog2(LATENCY+1).
//  Sub-module mem_lane_align (combinational):
//   - inputs: addr[1:0], size, unsigned, old word, wdata;
//   - outputs: extended load value, merged store word, misalign flag.
//  Top level holds the FSM, the init index ($clog2(DEPTH) bits), the wait counter
//  and the reg array.
// TESTING
//  1 rst pulse, DEPTH=64 -> req_ready=0 for 64 cycles, then init_done=1; LW 0x10 -> 0x00000000.
//  2 SW 0x8 0xDEADBEEF; LB 0x9 -> 0xFFFFFFBE; LBU 0x9 -> 0x000000BE; LH 0xA -> 0xFFFFDEAD.
//  3 after test 2: SB 0xB 0x12 then LW 0x8 -> 0x12ADBEEF (other lanes intact).
//  4 LH 0x3 -> rsp_err=1, rdata=0; SW 0x100 0x55 (DEPTH=64) -> rsp_err=1, no word changed.
//  5 LATENCY=3: accept at edge n -> rsp_valid at n+4; rsp_ready=0 for 5 cycles -> rsp stable, req_ready=0.
//  6 rst during WAIT of SW 0x4 0xAAAA5555 -> rsp_valid=0 at once; after re-init, LW 0x4 -> 0.

Source files
------------

// File: rtl/data_memory_ctrl_pkg.sv
// rtl/data_memory_ctrl_pkg.sv - shared types and constants for the data memory controller
// Contents:
//   SZ_B/SZ_H/SZ_W  access size encodings (2'b11 is illegal)
//   state_t         controller FSM states
//   lat_cnt_w()     wait counter width for a given latency
package data_mem_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  typedef enum logic [1:0] {INIT, IDLE, WAIT, RESP} state_t;

  // $clog2(LATENCY+1), kept at least 1 bit so LATENCY=0 still gives a legal vector
  function automatic int lat_cnt_w(input int latency);
    return (latency < 1) ? 1 : $clog2(latency + 1);
  endfunction

endpackage

// File: rtl/data_memory_ctrl_if.sv
// rtl/data_memory_ctrl_if.sv - request/response bus of the data memory controller
// Signals:
//   req_valid/req_ready           request handshake
//   req_we/req_size/req_unsigned  access kind
//   req_addr/req_wdata            byte address, right-aligned store data
//   rsp_valid/rsp_ready           response handshake
//   rsp_rdata/rsp_err             extended load data, error flag
//   init_done                     init sweep complete
// Modports: master drives requests, slave is the memory.
interface data_memory_ctrl_if #(
  parameter int ADDR_W = 32
);

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;
  logic              init_done;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, init_done
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, init_done
  );

endinterface

// File: rtl/data_memory_ctrl_mem_lane_align.sv
// rtl/data_memory_ctrl_mem_lane_align.sv - little-endian byte/half/word lane steering
// Ports:
//   addr        in   2   byte offset within the word
//   size        in   2   access size (SZ_B/SZ_H/SZ_W, 11 illegal)
//   uns         in   1   zero-extend loads when 1, sign-extend when 0
//   old_word    in   32  current word contents
//   wdata       in   32  right-aligned store data
//   load_val    out  32  extended load result (0 for illegal size)
//   store_word  out  32  old word with the addressed lanes replaced
//   misalign    out  1   half on odd byte or word not on a word boundary
module mem_lane_align (
  input  logic [1:0]  addr,
  input  logic [1:0]  size,
  input  logic        uns,
  input  logic [31:0] old_word,
  input  logic [31:0] wdata,
  output logic [31:0] load_val,
  output logic [31:0] store_word,
  output logic        misalign
);
  import data_mem_pkg::*;

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    lane_b     = old_word[8*addr +: 8];
    lane_h     = old_word[16*addr[1] +: 16];
    load_val   = '0;
    store_word = old_word;
    misalign   = 1'b0;
    case (size)
      SZ_B: begin
        load_val = uns ? {24'b0, lane_b} : {{24{lane_b[7]}}, lane_b};
        store_word[8*addr +: 8] = wdata[7:0];
      end
      SZ_H: begin
        load_val = uns ? {16'b0, lane_h} : {{16{lane_h[15]}}, lane_h};
        store_word[16*addr[1] +: 16] = wdata[15:0];
        misalign = addr[0];
      end
      SZ_W: begin
        load_val   = old_word;
        store_word = wdata;
        misalign   = |addr;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/data_memory_ctrl.sv
// rtl/data_memory_ctrl.sv - load/store data memory with handshake, wait states and init sweep
// Ports:
//   clk   in     1  clock, rising edge
//   rst   in     1  asynchronous, active-high reset
//   bus   slave     request/response bus (see data_memory_ctrl_if)
// Parameters: DEPTH words (power of 2), ADDR_W byte-address bits,
//   LATENCY wait cycles (0..15), INIT_CLEAR zero the array after reset.
module data_memory_ctrl #(
  parameter int DEPTH      = 64,
  parameter int ADDR_W     = 32,
  parameter int LATENCY    = 1,
  parameter int INIT_CLEAR = 1
) (
  input logic               clk,
  input logic               rst,
  data_memory_ctrl_if.slave bus
);
  import data_mem_pkg::*;

  localparam int              IDX_W    = $clog2(DEPTH);
  localparam int              CNT_W    = lat_cnt_w(LATENCY);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DEPTH - 1);

  state_t            state;
  state_t            state_nx;
  logic [IDX_W-1:0]  idx;
  logic [CNT_W-1:0]  cnt;

  logic              lat_we;
  logic              lat_uns;
  logic [1:0]        lat_size;
  logic [ADDR_W-1:0] lat_addr;
  logic [31:0]       lat_wdata;

  logic [31:0]       mem [DEPTH];

  logic              rsp_valid_q;
  logic              rsp_err_q;
  logic [31:0]       rsp_rdata_q;
  logic              init_done_q;

  logic              accept;
  logic              access;
  logic              rsp_take;
  logic              init_we;

  logic [IDX_W-1:0]  widx;
  logic [31:0]       old_word;
  logic [31:0]       load_val;
  logic [31:0]       store_word;
  logic              misalign;
  logic              illegal;
  logic              oor;
  logic              err;

  assign widx     = lat_addr[IDX_W+1:2];
  assign old_word = mem[widx];
  assign illegal  = (lat_size == 2'b11);
  assign err      = illegal | misalign | oor;

  // DEPTH is a power of 2, so a word index is out of range exactly when any
  // address bit above the index field is set.
  generate
    if (ADDR_W > IDX_W + 2) begin : g_oor
      assign oor = |lat_addr[ADDR_W-1:IDX_W+2];
    end else begin : g_no_oor
      assign oor = 1'b0;
    end
  endgenerate

  mem_lane_align u_align (
    .addr       (lat_addr[1:0]),
    .size       (lat_size),
    .uns        (lat_uns),
    .old_word   (old_word),
    .wdata      (lat_wdata),
    .load_val   (load_val),
    .store_word (store_word),
    .misalign   (misalign)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= INIT;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    access   = 1'b0;
    rsp_take = 1'b0;
    init_we  = 1'b0;
    case (state)
      INIT: begin
        init_we = (INIT_CLEAR != 0);
        if (INIT_CLEAR == 0 || idx == IDX_LAST) state_nx = IDLE;
      end
      IDLE: begin
        if (bus.req_valid) begin
          accept   = 1'b1;
          state_nx = WAIT;
        end
      end
      WAIT: begin
        if (cnt == '0) begin
          access   = 1'b1;
          state_nx = RESP;
        end
      end
      RESP: begin
        // Returning to IDLE first keeps a new request out of the handshake cycle.
        if (bus.rsp_ready) begin
          rsp_take = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = INIT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx         <= '0;
      cnt         <= '0;
      lat_we      <= 1'b0;
      lat_uns     <= 1'b0;
      lat_size    <= 2'b00;
      lat_addr    <= '0;
      lat_wdata   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      init_done_q <= 1'b0;
    end else begin
      if (state == INIT) begin
        idx <= idx + 1'b1;
        if (state_nx == IDLE) init_done_q <= 1'b1;
      end
      if (accept) begin
        lat_we    <= bus.req_we;
        lat_uns   <= bus.req_unsigned;
        lat_size  <= bus.req_size;
        lat_addr  <= bus.req_addr;
        lat_wdata <= bus.req_wdata;
        cnt       <= CNT_INIT;
      end else if (state == WAIT && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
      if (access) begin
        rsp_valid_q <= 1'b1;
        rsp_err_q   <= err;
        rsp_rdata_q <= (lat_we || err) ? 32'h0 : load_val;
      end else if (rsp_take) begin
        rsp_valid_q <= 1'b0;
      end
    end
  end

  // No reset on the array itself; the INIT sweep clears it. The FSM's async
  // reset forces INIT, so an access edge can never land while rst is high.
  always_ff @(posedge clk) begin
    if (init_we) begin
      mem[idx] <= '0;
    end else if (access && lat_we && !err) begin
      mem[widx] <= store_word;
    end
  end

  assign bus.req_ready = (state == IDLE);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.init_done = init_done_q;

endmodule

// File: tb/tb_data_memory_ctrl.sv
// tb/tb_data_memory_ctrl.sv - scoreboard bench for data_memory_ctrl
module tb_data_memory_ctrl;

  localparam int DEPTH   = 64;
  localparam int ADDR_W  = 32;
  localparam int LATENCY = 3;

  logic clk = 1'b0;
  logic rst;
  int   n_pass = 0;
  int   n_chk  = 0;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  rsp_t       sb_q[$];
  logic [7:0] mb [DEPTH*4];

  data_memory_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

  data_memory_ctrl #(
    .DEPTH      (DEPTH),
    .ADDR_W     (ADDR_W),
    .LATENCY    (LATENCY),
    .INIT_CLEAR (1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  function automatic logic model_err(input logic [1:0] sz, input logic [31:0] a);
    return (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00)
           || (a >= 32'(DEPTH*4));
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] sz, input logic uns,
                                             input logic [31:0] a);
    logic [7:0]  b;
    logic [15:0] h;
    b = mb[a];
    h = {mb[a+1], mb[a]};
    case (sz)
      2'b00:   return uns ? {24'b0, b} : {{24{b[7]}}, b};
      2'b01:   return uns ? {16'b0, h} : {{16{h[15]}}, h};
      default: return {mb[a+3], mb[a+2], mb[a+1], mb[a]};
    endcase
  endfunction

  task automatic model_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
    mb[a] = wd[7:0];
    if (sz != 2'b00) mb[a+1] = wd[15:8];
    if (sz == 2'b10) begin
      mb[a+2] = wd[23:16];
      mb[a+3] = wd[31:24];
    end
  endtask

  task automatic idle_inputs();
    bus.req_valid    = 1'b0;
    bus.req_we       = 1'b0;
    bus.req_size     = 2'b00;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = '0;
    bus.req_wdata    = '0;
    bus.rsp_ready    = 1'b0;
  endtask

  // Asserts reset, checks the reset outputs, releases just after an edge and
  // counts the cycles spent sweeping before req_ready rises.
  task automatic init_seq();
    int n;
    rst = 1'b1;
    idle_inputs();
    sb_q.delete();
    for (int i = 0; i < DEPTH*4; i++) mb[i] = 8'h00;
    #3;
    check("rst_req_ready", 32'(bus.req_ready), 32'd0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
    check("rst_rsp_err",   32'(bus.rsp_err), 32'd0);
    check("rst_init_done", 32'(bus.init_done), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    n = 0;
    @(negedge clk);
    while (!bus.req_ready && n < 300) begin
      n++;
      @(negedge clk);
    end
    check("init_cycles", 32'(n), 32'(DEPTH));
    check("init_done",   32'(bus.init_done), 32'd1);
  endtask

  task automatic send(input string tag, input logic we, input logic [1:0] sz, input logic uns,
                      input logic [31:0] addr, input logic [31:0] wd,
                      input logic [31:0] exp_rdata, input logic exp_err, input int stall);
    int   n;
    rsp_t exp;
    @(negedge clk);
    bus.req_valid    = 1'b1;
    bus.req_we       = we;
    bus.req_size     = sz;
    bus.req_unsigned = uns;
    bus.req_addr     = addr;
    bus.req_wdata    = wd;
    n = 0;
    while (!bus.req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.req_ready) begin
      check({tag, "_accept"}, 32'(bus.req_ready), 32'd1);
      idle_inputs();
      return;
    end
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    sb_q.push_back('{rdata: exp_rdata, err: exp_err});
    if (we && !exp_err) model_store(sz, addr, wd);
    // Accept at edge T, rsp_valid rises at T+1+LATENCY: visible at the
    // LATENCY+2'th falling edge counted from the accept edge.
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.rsp_valid && n < 50);
    check({tag, "_latency"}, 32'(n), 32'(LATENCY + 2));
    if (!bus.rsp_valid) return;
    exp = sb_q.pop_front();
    for (int s = 0; s < stall; s++) begin
      check({tag, "_hold_valid"}, 32'(bus.rsp_valid), 32'd1);
      check({tag, "_hold_rdata"}, bus.rsp_rdata, exp.rdata);
      check({tag, "_hold_ready"}, 32'(bus.req_ready), 32'd0);
      @(negedge clk);
    end
    check({tag, "_rdata"}, bus.rsp_rdata, exp.rdata);
    check({tag, "_err"},   32'(bus.rsp_err), 32'(exp.err));
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1 bus.rsp_ready = 1'b0;
    @(negedge clk);
    check({tag, "_drop"}, 32'(bus.rsp_valid), 32'd0);
  endtask

  task automatic rand_op(input int k);
    logic        we;
    logic        uns;
    logic [1:0]  sz;
    logic [31:0] a;
    logic [31:0] wd;
    logic        e;
    we  = 1'($urandom_range(0, 1));
    uns = 1'($urandom_range(0, 1));
    sz  = 2'($urandom_range(0, 3));
    a   = 32'($urandom_range(0, DEPTH*4 + 15));
    wd  = $urandom;
    if ($urandom_range(0, 3) != 0) begin
      if (sz == 2'b01) a[0] = 1'b0;
      if (sz == 2'b10) a[1:0] = 2'b00;
    end
    e = model_err(sz, a);
    send($sformatf("rnd%0d", k), we, sz, uns, a, wd,
         (we || e) ? 32'h0 : model_load(sz, uns, a), e, 0);
  endtask

  initial begin
    init_seq();

    send("lw_10",  1'b0, 2'b10, 1'b0, 32'h10, 32'h0,        32'h00000000, 1'b0, 0);
    send("sw_8",   1'b1, 2'b10, 1'b0, 32'h08, 32'hDEADBEEF, 32'h00000000, 1'b0, 0);
    send("lb_9",   1'b0, 2'b00, 1'b0, 32'h09, 32'h0,        32'hFFFFFFBE, 1'b0, 0);
    send("lbu_9",  1'b0, 2'b00, 1'b1, 32'h09, 32'h0,        32'h000000BE, 1'b0, 0);
    send("lh_a",   1'b0, 2'b01, 1'b0, 32'h0A, 32'h0,        32'hFFFFDEAD, 1'b0, 0);
    send("sb_b",   1'b1, 2'b00, 1'b0, 32'h0B, 32'h12,       32'h00000000, 1'b0, 0);
    send("lw_8",   1'b0, 2'b10, 1'b0, 32'h08, 32'h0,        32'h12ADBEEF, 1'b0, 0);
    send("lhu_8",  1'b0, 2'b01, 1'b1, 32'h08, 32'h0,        32'h0000BEEF, 1'b0, 0);

    send("lh_3",   1'b0, 2'b01, 1'b0, 32'h03, 32'h0,        32'h00000000, 1'b1, 0);
    send("sw_100", 1'b1, 2'b10, 1'b0, 32'h100, 32'h55,      32'h00000000, 1'b1, 0);
    send("lw_0",   1'b0, 2'b10, 1'b0, 32'h00, 32'h0,        32'h00000000, 1'b0, 0);
    send("sz11",   1'b0, 2'b11, 1'b0, 32'h08, 32'h0,        32'h00000000, 1'b1, 0);
    send("sw_mis", 1'b1, 2'b10, 1'b0, 32'h0A, 32'hCAFEF00D, 32'h00000000, 1'b1, 0);
    send("lw_8b",  1'b0, 2'b10, 1'b0, 32'h08, 32'h0,        32'h12ADBEEF, 1'b0, 0);

    send("stall",  1'b0, 2'b10, 1'b0, 32'h08, 32'h0,        32'h12ADBEEF, 1'b0, 5);

    for (int k = 0; k < 40; k++) rand_op(k);

    // Reset in the middle of a store's wait states.
    send("sw_4",   1'b1, 2'b10, 1'b0, 32'h04, 32'h11111111, 32'h00000000, 1'b0, 0);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_size  = 2'b10;
    bus.req_addr  = 32'h04;
    bus.req_wdata = 32'hAAAA5555;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(posedge clk);
    #1;
    init_seq();
    send("lw_4",   1'b0, 2'b10, 1'b0, 32'h04, 32'h0,        32'h00000000, 1'b0, 0);

    check("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
